calculator_inv_seq: RTL

//  Sequential inverse-operation calculator: the "undo" companion to the
//  8-bit add/multiply calculator. op=0 computes subtraction (in0 - in1),
//  op=1 computes unsigned division (in0 / in1) using an iterative

---
 rtl/calculator_inv_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/calculator_inv_seq.sv
// Purpose : 8-bit inverse calculator; op=0 subtract (mod 256), op=1 unsigned restoring divide.
// Latency : subtract 1 cycle, divide 9 cycles (accept edge to resp_val).
// Backpres: result held in DONE until resp_val & resp_rdy; req_rdy only in IDLE, so no overlap.
//
// Ports:
//   clk, reset               clock and asynchronous active-high reset
//   req_val / req_rdy        request handshake; req_in0, req_in1, req_op sampled at accept
//   resp_val / resp_rdy      response handshake; resp_result = difference or quotient
//   resp_rem                 remainder output, present only when CALC_REM_EN is defined
//
// Optional feature macro: CALC_REM_EN (adds the resp_rem port and its output register).
module calculator_inv_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_val,
  output logic       req_rdy,
  input  logic [7:0] req_in0,
  input  logic [7:0] req_in1,
  input  logic       req_op,
  output logic       resp_val,
  input  logic       resp_rdy,
`ifdef CALC_REM_EN
  output logic [7:0] resp_rem,
`endif
  output logic [7:0] resp_result
);

  // Subtraction completes on the accept edge itself, so it goes straight
  // from IDLE to DONE and needs no state of its own.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [7:0] dvd_q,   dvd_d;    // dividend, shifted out MSB-first; quotient shifts in at LSB
  logic [7:0] dvs_q,   dvs_d;    // divisor
  logic [7:0] rem_q,   rem_d;    // partial remainder
  logic [7:0] result_q, result_d;
`ifdef CALC_REM_EN
  logic [7:0] rem_out_q, rem_out_d;
`endif

  // One restoring step. Before the shift the partial remainder is always
  // below 128 (it never exceeds the dividend bits consumed so far), so
  // carrying rem_q[7] into a 9-bit compare is equivalent to dropping it.
  logic [8:0] rem_wide;
  logic       step_ge;
  logic [7:0] rem_next;
  logic [7:0] quo_next;

  always_comb begin
    rem_wide = {rem_q, dvd_q[7]};
    step_ge  = (rem_wide >= {1'b0, dvs_q});
    rem_next = step_ge ? (rem_wide[7:0] - dvs_q) : rem_wide[7:0];
    quo_next = {dvd_q[6:0], step_ge};
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    result_d = result_q;
`ifdef CALC_REM_EN
    rem_out_d = rem_out_q;
`endif
    req_rdy  = 1'b0;
    resp_val = 1'b0;

    case (state_q)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_val) begin
          dvd_d   = req_in0;
          dvs_d   = req_in1;
          rem_d   = 8'h00;
          count_d = 3'd0;
          if (req_op) begin
            state_d = DIV;
          end else begin
            result_d = req_in0 - req_in1;
`ifdef CALC_REM_EN
            rem_out_d = 8'h00;
`endif
            state_d  = DONE;
          end
        end
      end

      DIV: begin
        dvd_d   = quo_next;
        rem_d   = rem_next;
        count_d = count_q + 3'd1;
        if (count_q == 3'd7) begin
          result_d = quo_next;
`ifdef CALC_REM_EN
          rem_out_d = rem_next;
`endif
          state_d  = DONE;
        end
      end

      DONE: begin
        resp_val = 1'b1;
        if (resp_rdy) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= 3'd0;
      dvd_q    <= 8'h00;
      dvs_q    <= 8'h00;
      rem_q    <= 8'h00;
      result_q <= 8'h00;
`ifdef CALC_REM_EN
      rem_out_q <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      result_q <= result_d;
`ifdef CALC_REM_EN
      rem_out_q <= rem_out_d;
`endif
    end
  end

  assign resp_result = result_q;
`ifdef CALC_REM_EN
  assign resp_rem = rem_out_q;
`endif

endmodule
